// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter.
//   state_e  : arbiter state (IDLE = no owner, GRANT = one owner)
//   NUM_REQ  : number of requesters
//   IDX_W    : width of a requester index
package round_robin_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

endpackage : round_robin_arbiter_pkg

// File: rtl/round_robin_arbiter_prio_enc4.sv
// 4-input fixed priority encoder, bit 0 highest priority.
//   req   : input request vector
//   idx   : index of lowest set bit (0 when none set)
//   valid : 1 when any bit of req is set
module prio_enc4
  import round_robin_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b1;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
    else             valid = 1'b0;
  end

endmodule : prio_enc4

// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
//   MAX_HOLD   : max consecutive cycles an owner keeps the grant (2..256)
//   Clk        : clock, rising edge
//   Rst_n      : synchronous active-low reset
//   Req        : request vector, one bit per requester
//   Release    : owner is done (only looked at while granted)
//   Grant      : registered one-hot grant, zero when no owner
//   GrantId    : registered binary owner index, zero when no owner
//   GrantValid : registered, high exactly when Grant is non-zero
//   Timeout    : one-cycle pulse after a grant is revoked by hold expiry
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)
(
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               Release,
  output logic [NUM_REQ-1:0] Grant,
  output logic [IDX_W-1:0]   GrantId,
  output logic               GrantValid,
  output logic               Timeout
);

  localparam int unsigned    CNT_W     = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q,       state_d;
  logic [IDX_W-1:0]   ptr_q,         ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q,    hold_cnt_d;
  logic [NUM_REQ-1:0] grant_q,       grant_d;
  logic [IDX_W-1:0]   grant_id_q,    grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic               timeout_q,     timeout_d;

  logic [NUM_REQ-1:0] rot_req;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               expire;
  logic               dropped;

  // Rotate so that requester ptr_q lands on bit 0; the fixed encoder then
  // yields the first set bit in pointer order. Index arithmetic is IDX_W
  // bits wide, so the modulo-4 wrap is implicit.
  always_comb begin
    rot_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rot_req[i] = Req[IDX_W'(i) + ptr_q];
    end
  end

  prio_enc4 u_prio_enc4 (
    .req   (rot_req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign win_idx = enc_idx + ptr_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    expire        = (hold_cnt_q == HOLD_LAST);
    dropped       = !Req[grant_id_q];

    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d       = GRANT;
          grant_d       = NUM_REQ'(1) << win_idx;
          grant_id_d    = win_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      GRANT: begin
        if (Release || dropped || expire) begin
          state_d       = IDLE;
          ptr_d         = grant_id_q + IDX_W'(1);
          hold_cnt_d    = '0;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          // Only a pure expiry is reported; a voluntary exit wins.
          timeout_d     = expire && !Release && !dropped;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign Grant      = grant_q;
  assign GrantId    = grant_id_q;
  assign GrantValid = grant_valid_q;
  assign Timeout    = timeout_q;

endmodule : round_robin_arbiter
